// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC, ROM addressing, instruction queue to decode.
// Optional macro FETCH_MISALIGN_CHK_EN traps misaligned redirect targets.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [9:0]  rom_addr,
    input  logic [31:0] rom_data,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] pc,
    output logic        misalign
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        HALT = 2'd1,
        ERR  = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [31:0]   q_pc    [DEPTH];
    logic [31:0]   q_instr [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;
    logic [31:0]   target;
    logic          bad_tgt;
    logic          fetch_en;
    logic          redir_go;
    logic          pop;
    logic          push;

`ifdef FETCH_MISALIGN_CHK_EN
    assign target  = redirect_pc;
    assign bad_tgt = redirect_pc[1:0] != 2'b00;
`else
    assign target  = redirect_pc & 32'hFFFF_FFFC;
    assign bad_tgt = 1'b0;
`endif

    assign rom_addr = pc[11:2];
    assign if_valid = count != '0;
    assign if_instr = if_valid ? q_instr[head] : 32'h0;
    assign if_pc    = if_valid ? q_pc[head] : 32'h0;
    assign pop      = if_valid && if_ready;
    assign push     = fetch_en && !redirect && (count < FULL || pop);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state: redirect wins over halt; a bad target traps into ERR
    always_comb begin
        state_nx = state;
        unique case (state)
            RUN, HALT: begin
                if (redirect) begin
                    if (bad_tgt) begin
                        state_nx = ERR;
                    end else if (halt) begin
                        state_nx = HALT;
                    end else begin
                        state_nx = RUN;
                    end
                end else if (halt) begin
                    state_nx = HALT;
                end
            end
            ERR:     state_nx = ERR;
            default: state_nx = RUN;
        endcase
    end

    // State-decoded controls
    always_comb begin
        fetch_en = state == RUN;
        redir_go = redirect && (state != ERR);
        misalign = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
        misalign = state == ERR;
`endif
    end

    // PC and queue pointers; a redirect flushes and drops any push
    always_ff @(posedge clk) begin
        if (rst) begin
            pc    <= RESET_PC;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (redir_go) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            if (!bad_tgt) begin
                pc <= target;
            end
        end else begin
            if (push) begin
                tail <= tail + PW'(1);
                pc   <= pc + 32'd4;
            end
            if (pop) begin
                head <= head + PW'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Queue storage, written at the tail on push
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            q_pc[tail]    <= pc;
            q_instr[tail] <= rom_data;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a ROM whose word i holds 0x1000_0000+i.
// Misalign trap expectations follow FETCH_MISALIGN_CHK_EN.
module tb_instr_fetch;

    localparam logic [31:0] B = 32'h1000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  rom_addr;
    logic [31:0] rom_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] pc;
    logic        misalign;

    int checks = 0;
    int errs   = 0;

    always #5 clk = ~clk;

    assign rom_data = B + {22'd0, rom_addr};

    instr_fetch #(
        .RESET_PC(32'h0000_0000),
        .DEPTH   (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .halt       (halt),
        .if_valid   (if_valid),
        .if_ready   (if_ready),
        .if_instr   (if_instr),
        .if_pc      (if_pc),
        .pc         (pc),
        .misalign   (misalign)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Leaves the bench at a negedge with rst just released, queue empty
    task automatic do_reset();
        rst         = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        halt        = 1'b0;
        if_ready    = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        // Reset values
        do_reset();
        rst = 1'b1;
        @(negedge clk);
        chk("rst_pc", pc, 32'h0);
        chk("rst_valid", {31'd0, if_valid}, 32'd0);
        chk("rst_instr", if_instr, 32'h0);
        chk("rst_ifpc", if_pc, 32'h0);
        chk("rst_mis", {31'd0, misalign}, 32'd0);
        chk("rst_addr", {22'd0, rom_addr}, 32'd0);

        // Streaming with ready held high
        do_reset();
        if_ready = 1'b1;
        chk("s_first_valid", {31'd0, if_valid}, 32'd0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("s_valid", {31'd0, if_valid}, 32'd1);
            chk("s_instr", if_instr, B + k);
            chk("s_ifpc", if_pc, 32'(4 * k));
            chk("s_pc", pc, 32'(4 * (k + 1)));
        end

        // Backpressure: queue saturates, head and pc hold
        do_reset();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_head", if_instr, B);
            chk("bp_ifpc", if_pc, 32'h0);
        end
        chk("bp_pc", pc, 32'h8);
        chk("bp_addr", {22'd0, rom_addr}, 32'd2);
        for (int k = 0; k < 6; k++) begin
            chk("bp_rel_instr", if_instr, B + k);
            chk("bp_rel_ifpc", if_pc, 32'(4 * k));
            if_ready = 1'b1;
            @(negedge clk);
        end

        // Redirect while full with a same-cycle pop
        do_reset();
        repeat (3) @(negedge clk);
        chk("rd_full_pc", pc, 32'h8);
        redirect    = 1'b1;
        redirect_pc = 32'h40;
        if_ready    = 1'b1;
        @(negedge clk);
        redirect = 1'b0;
        chk("rd_flush", {31'd0, if_valid}, 32'd0);
        chk("rd_pc", pc, 32'h40);
        chk("rd_addr", {22'd0, rom_addr}, 32'd16);
        @(negedge clk);
        chk("rd_valid", {31'd0, if_valid}, 32'd1);
        chk("rd_ifpc", if_pc, 32'h40);
        chk("rd_instr", if_instr, B + 16);

        // Halt at pc 0x10, drain, then resume via redirect
        do_reset();
        if_ready = 1'b1;
        repeat (4) @(negedge clk);
        chk("h_pc", pc, 32'h10);
        halt = 1'b1;
        @(negedge clk);
        halt = 1'b0;
        chk("h_pc_frozen", pc, 32'h14);
        chk("h_last", if_instr, B + 4);
        repeat (3) @(negedge clk);
        chk("h_drained", {31'd0, if_valid}, 32'd0);
        chk("h_instr0", if_instr, 32'h0);
        chk("h_pc_hold", pc, 32'h14);
        redirect    = 1'b1;
        redirect_pc = 32'h0;
        @(negedge clk);
        redirect = 1'b0;
        chk("h_res_pc", pc, 32'h0);
        @(negedge clk);
        chk("h_res_valid", {31'd0, if_valid}, 32'd1);
        chk("h_res_instr", if_instr, B);
        @(negedge clk);
        chk("h_res_next", if_instr, B + 1);

        // Halt and redirect together: flush, load target, stay halted
        halt        = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h80;
        @(negedge clk);
        halt     = 1'b0;
        redirect = 1'b0;
        repeat (2) @(negedge clk);
        chk("hr_pc", pc, 32'h80);
        chk("hr_valid", {31'd0, if_valid}, 32'd0);

        // PC wrap at the top of the address space
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        @(negedge clk);
        redirect = 1'b0;
        chk("w_addr", {22'd0, rom_addr}, 32'd1023);
        @(negedge clk);
        chk("w_pc", pc, 32'h0);
        chk("w_addr0", {22'd0, rom_addr}, 32'd0);
        chk("w_ifpc", if_pc, 32'hFFFF_FFFC);
        chk("w_instr", if_instr, B + 1023);

        // Misaligned redirect
        do_reset();
        if_ready    = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h42;
        @(negedge clk);
        redirect = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
        for (int k = 0; k < 3; k++) begin
            chk("m_flag", {31'd0, misalign}, 32'd1);
            chk("m_valid", {31'd0, if_valid}, 32'd0);
            chk("m_pc", pc, 32'h0);
            @(negedge clk);
        end
        redirect    = 1'b1;
        redirect_pc = 32'h80;
        @(negedge clk);
        redirect = 1'b0;
        @(negedge clk);
        chk("m_err_pc", pc, 32'h0);
        chk("m_err_valid", {31'd0, if_valid}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("m_clear", {31'd0, misalign}, 32'd0);
`else
        chk("m_flag", {31'd0, misalign}, 32'd0);
        chk("m_pc", pc, 32'h40);
        @(negedge clk);
        chk("m_valid", {31'd0, if_valid}, 32'd1);
        chk("m_ifpc", if_pc, 32'h40);
        chk("m_instr", if_instr, B + 16);
`endif

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
